// File: rtl/line_window_buffer_if.sv
// Pixel-stream and window bundle for line_window_buffer.
// master drives en/px_in; slave returns window, flags and counters.
interface line_window_buffer_if #(
   parameter int COLS      = 32,
   parameter int ROWS      = 32,
   parameter int BIT_WIDTH = 8,
   parameter int K         = 5,
   parameter int CH        = 1
);
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   logic                          en;
   logic [CH*BIT_WIDTH-1:0]       px_in;
   logic [CH*K*K*BIT_WIDTH-1:0]   win_out;
   logic                          win_valid;
   logic                          frame_done;
   logic [CW-1:0]                 col_cnt;
   logic [RW-1:0]                 row_cnt;

   modport master (
      output en, px_in,
      input  win_out, win_valid, frame_done, col_cnt, row_cnt
   );

   modport slave (
      input  en, px_in,
      output win_out, win_valid, frame_done, col_cnt, row_cnt
   );
endinterface

// File: rtl/line_window_buffer.sv
// K x K sliding-window line buffer over a raster pixel stream, CH channels.
// Ports: clk, rst (sync, active-high), lwb (slave: en, px_in -> win_out, win_valid, frame_done, col_cnt, row_cnt).
module line_window_buffer #(
   parameter int COLS      = 32,
   parameter int ROWS      = 32,
   parameter int BIT_WIDTH = 8,
   parameter int K         = 5,
   parameter int CH        = 1
) (
   input logic clk,
   input logic rst,
   line_window_buffer_if.slave lwb
);
   localparam int L  = (K-1)*COLS + K;
   localparam int PW = CH*BIT_WIDTH;
   localparam int CW = $clog2(COLS);
   localparam int RW = $clog2(ROWS);

   localparam logic [CW-1:0] COL_LAST = CW'(COLS-1);
   localparam logic [RW-1:0] ROW_LAST = RW'(ROWS-1);
   localparam logic [CW-1:0] COL_WIN  = CW'(K-1);
   localparam logic [RW-1:0] ROW_WIN  = RW'(K-1);

   // One chain word holds all channels so they shift in lockstep.
   logic [PW-1:0] sr_q [L];

   logic [CW-1:0] col_q, col_d;
   logic [RW-1:0] row_q, row_d;
   logic          valid_q, valid_d;
   logic          done_q, done_d;

   logic [CH*K*K*BIT_WIDTH-1:0] win;

   always_comb begin
      col_d   = col_q;
      row_d   = row_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      if (lwb.en) begin
         // Gating by position keeps row-straddling and stale windows out.
         valid_d = (row_q >= ROW_WIN) && (col_q >= COL_WIN);
         done_d  = (row_q == ROW_LAST) && (col_q == COL_LAST);
         if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < L; n++) sr_q[n] <= '0;
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         if (lwb.en) begin
            sr_q[0] <= lwb.px_in;
            for (int n = 1; n < L; n++) sr_q[n] <= sr_q[n-1];
         end
         col_q   <= col_d;
         row_q   <= row_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   // Top-left of the window is the oldest tap, bottom-right is sr_q[0].
   always_comb begin
      win = '0;
      for (int c = 0; c < CH; c++)
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++)
               win[((c*K + i)*K + j)*BIT_WIDTH +: BIT_WIDTH] =
                  sr_q[(K-1-i)*COLS + (K-1-j)][c*BIT_WIDTH +: BIT_WIDTH];
   end

   assign lwb.win_out    = win;
   assign lwb.win_valid  = valid_q;
   assign lwb.frame_done = done_q;
   assign lwb.col_cnt    = col_q;
   assign lwb.row_cnt    = row_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Scoreboard bench for line_window_buffer: 6x6 frame, K=3, CH=1 and CH=2.
// Expected windows are built from pixel coordinates, not from the chain.
module tb_line_window_buffer;
   localparam int C  = 6;
   localparam int R  = 6;
   localparam int K  = 3;
   localparam int BW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   line_window_buffer_if #(.COLS(C), .ROWS(R), .BIT_WIDTH(BW), .K(K), .CH(1)) b1 ();
   line_window_buffer_if #(.COLS(C), .ROWS(R), .BIT_WIDTH(BW), .K(K), .CH(2)) b2 ();

   line_window_buffer #(.COLS(C), .ROWS(R), .BIT_WIDTH(BW), .K(K), .CH(1)) u_dut1 (
      .clk(clk), .rst(rst), .lwb(b1.slave)
   );
   line_window_buffer #(.COLS(C), .ROWS(R), .BIT_WIDTH(BW), .K(K), .CH(2)) u_dut2 (
      .clk(clk), .rst(rst), .lwb(b2.slave)
   );

   typedef struct {
      logic [255:0] w1;
      logic [255:0] w2;
      logic         fd;
   } exp_t;

   exp_t sb[$];

   int n_cmp = 0;
   int n_bad = 0;
   int mr = 0;
   int mc = 0;
   int base = 0;
   int pulses = 0;
   int fds = 0;
   bit last_ok = 0;
   logic [255:0] last_w1;
   logic [255:0] last_w2;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] exp_win(int r, int c, int b, int nch);
      logic [255:0] w;
      w = '0;
      for (int ch = 0; ch < nch; ch++)
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K; j++) begin
               int v;
               v = b + 200*ch + (r-K+1+i)*C + (c-K+1+j);
               w[((ch*K + i)*K + j)*BW +: BW] = 8'(v);
            end
      return w;
   endfunction

   task automatic step(input bit e);
      int   v;
      bit   q;
      bit   expv;
      bit   expfd;
      exp_t x;
      v     = base + mr*C + mc;
      q     = (mr >= K-1) && (mc >= K-1);
      expv  = e && q;
      expfd = e && (mr == R-1) && (mc == C-1);
      b1.en    = e;
      b2.en    = e;
      b1.px_in = 8'(v);
      b2.px_in = {8'(v+200), 8'(v)};
      if (expv) begin
         x.w1 = exp_win(mr, mc, base, 1);
         x.w2 = exp_win(mr, mc, base, 2);
         x.fd = expfd;
         sb.push_back(x);
      end
      @(posedge clk);
      #1;
      chk("win_valid", 256'(b1.win_valid), 256'(expv));
      chk("win_valid_ch2", 256'(b2.win_valid), 256'(expv));
      chk("frame_done", 256'(b1.frame_done), 256'(expfd));
      if (b1.win_valid) pulses++;
      if (b1.frame_done) fds++;
      if (b1.win_valid && sb.size() > 0) begin
         x = sb.pop_front();
         chk("win_ch1", 256'(b1.win_out), x.w1);
         chk("win_ch2", 256'(b2.win_out), x.w2);
         chk("fd_with_last_win", 256'(b2.frame_done), 256'(x.fd));
      end
      if (e) begin
         last_ok = expv;
         if (expv) begin
            last_w1 = exp_win(mr, mc, base, 1);
            last_w2 = exp_win(mr, mc, base, 2);
         end
         if (mc == C-1) begin
            mc = 0;
            mr = (mr == R-1) ? 0 : mr + 1;
         end else begin
            mc++;
         end
      end else if (last_ok) begin
         chk("stall_win_ch1", 256'(b1.win_out), last_w1);
         chk("stall_win_ch2", 256'(b2.win_out), last_w2);
      end
      chk("col_cnt", 256'(b1.col_cnt), 256'(mc));
      chk("row_cnt", 256'(b1.row_cnt), 256'(mr));
      chk("col_cnt_ch2", 256'(b2.col_cnt), 256'(mc));
      chk("row_cnt_ch2", 256'(b2.row_cnt), 256'(mr));
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      b1.en    = 1'b1;
      b2.en    = 1'b1;
      b1.px_in = '1;
      b2.px_in = '1;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      mr      = 0;
      mc      = 0;
      last_ok = 0;
      pulses  = 0;
      fds     = 0;
      sb.delete();
   endtask

   task automatic frame(input int b, input bit toggle);
      base = b;
      for (int p = 0; p < R*C; p++) begin
         step(1'b1);
         if (toggle) step(1'b0);
      end
   endtask

   task automatic check_counts(input string tag, input int np, input int nf);
      chk({tag, "_pulses"}, 256'(pulses), 256'(np));
      chk({tag, "_frame_done"}, 256'(fds), 256'(nf));
      pulses = 0;
      fds    = 0;
   endtask

   initial begin
      b1.en    = 1'b0;
      b2.en    = 1'b0;
      b1.px_in = '0;
      b2.px_in = '0;

      do_reset();
      chk("rst_win1", 256'(b1.win_out), 256'(0));
      chk("rst_win2", 256'(b2.win_out), 256'(0));
      chk("rst_valid", 256'(b1.win_valid), 256'(0));
      chk("rst_done", 256'(b1.frame_done), 256'(0));
      chk("rst_col", 256'(b1.col_cnt), 256'(0));
      chk("rst_row", 256'(b1.row_cnt), 256'(0));

      frame(0, 1'b0);
      check_counts("frame0", 16, 1);

      frame(0, 1'b1);
      check_counts("stall", 16, 1);

      frame(0, 1'b0);
      frame(100, 1'b0);
      check_counts("b2b", 32, 2);

      base = 0;
      for (int p = 0; p < 20; p++) step(1'b1);
      do_reset();
      chk("mid_rst_col", 256'(b1.col_cnt), 256'(0));
      chk("mid_rst_row", 256'(b1.row_cnt), 256'(0));
      chk("mid_rst_win", 256'(b1.win_out), 256'(0));
      frame(50, 1'b0);
      check_counts("mid_rst", 16, 1);

      b1.en = 1'b0;
      b2.en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/line_window_buffer.md
Name: line_window_buffer

Overview:
- Parametrised multi-row, multi-channel line buffer for the convolution layers.
- Accepts a raster-ordered pixel stream, one pixel per enabled cycle, all channels in parallel.
- Presents a full K x K window per channel, flagged valid only when the window lies entirely inside the frame.
- Feeds the MAC array directly; generalises the single-row shift buffer with row/column tracking, valid generation and frame-end signalling.

Parameters:
- COLS, 32: frame width in pixels (>= K).
- ROWS, 32: frame height in pixels (>= K).
- BIT_WIDTH, 8: bits per pixel per channel.
- K, 5: window edge length (>= 2).
- CH, 1: parallel channels sharing one control path (>= 1).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  pixel accept; px_in is consumed on every rising edge with en=1.
- px_in  in  CH*BIT_WIDTH  one pixel for each channel; channel ch at bits [ch*BIT_WIDTH +: BIT_WIDTH].
- win_out  out  CH*K*K*BIT_WIDTH  current window, all channels.
- win_valid  out  1  win_out holds a complete in-frame window; one-cycle pulse per qualifying pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.
- col_cnt  out  $clog2(COLS)  column index of the next pixel expected.
- row_cnt  out  $clog2(ROWS)  row index of the next pixel expected.

Behaviour:
- Storage per channel:
  - Shift chain sr[0..L-1], with L = (K-1)*COLS + K.
  - On en: sr[0] <= pixel, sr[n] <= sr[n-1]; sr[0] is the newest pixel.
  - All channels shift together.
- Window mapping:
  - Element (i,j), i = row 0..K-1 (0 = top), j = column 0..K-1 (0 = left), equals sr[(K-1-i)*COLS + (K-1-j)].
  - Packed at win_out[((ch*K + i)*K + j)*BIT_WIDTH +: BIT_WIDTH].
  - win_out is combinational from the chain, so it reflects the chain state after the last accepted pixel.
- Counters:
  - col_cnt/row_cnt give the position of the pixel about to be accepted.
  - On en, col_cnt increments. At COLS-1 it wraps to 0 and row_cnt increments.
  - At row_cnt = ROWS-1 with col_cnt = COLS-1, both wrap to 0 (frame wrap).
- win_valid (registered):
  - Set on the edge that accepts a pixel whose (row, col) has row >= K-1 and col >= K-1; cleared on every other edge, including en=0 edges.
  - Latency: win_valid and the matching win_out appear together in the cycle after the edge that accepted the bottom-right pixel of the window.
  - (ROWS-K+1)*(COLS-K+1) pulses per frame.
  - Windows straddling a row boundary are never flagged.
- frame_done (registered): set on the edge accepting pixel (ROWS-1, COLS-1); cleared on every other edge. It coincides with the last win_valid of the frame.
- en=0: chain, counters and win_out hold; win_valid and frame_done go to 0.
- Back-to-back frames:
  - No gap required; the chain is not flushed.
  - Stale pixels from the previous frame never appear under win_valid=1, because gating is by counters.
- Reset:
  - Every sr entry is cleared to 0, so win_out = 0.
  - col_cnt = 0, row_cnt = 0, win_valid = 0, frame_done = 0.
  - rst overrides en in the same cycle.
  - Reset mid-frame discards the partial frame; the next accepted pixel is treated as (0,0).
- Widths: no arithmetic on pixel data; values pass through bit-exact.
- Counter compare constants sized to the counter widths.

Test Plan:
- Reset check: config COLS=6, ROWS=6, K=3, CH=1, BIT_WIDTH=8. Assert rst for 2 cycles -> win_out=0, win_valid=0, frame_done=0, col_cnt=0, row_cnt=0.
- Window contents and count: same config. Stream 36 pixels, value = row*6+col, en held high.
  - First win_valid in the cycle after pixel 14 is accepted, with window rows {0,1,2},{6,7,8},{12,13,14}.
  - Exactly 16 pulses in total.
  - No pulse after pixels at col 0 or col 1.
- Stall behaviour: same stream with en toggled 1,0,1,0... -> identical window sequence. win_valid never high in a cycle following an en=0 edge; counters and win_out frozen during stalls.
- Frame boundary: two frames back-to-back, second frame value = 100+row*6+col.
  - frame_done pulses once after pixel 35, simultaneously with the last win_valid (window {21,22,23},{27,28,29},{33,34,35}).
  - Second frame's first valid window = {100,101,102},{106,107,108},{112,113,114}.
- Mid-frame reset: assert rst after 20 pixels, then stream a fresh frame -> counters restart at (0,0). First valid window after the 15th new pixel contains only new-frame values; 16 pulses in total.
- Multi-channel: config CH=2, K=3. ch0 = row*6+col, ch1 = 200+row*6+col -> the ch1 window equals the ch0 window +200 element-wise at every win_valid, with ch0 in the low slice of win_out.
